// File: rtl/pipeline_spi_defs_pkg.sv
// Opcodes, FSM state encoding and payload sizing helpers shared by the SPI
// control-shadow block and its byte slave.
package pipeline_spi_defs;

  localparam logic [7:0] OP_MODE         = 8'h01;
  localparam logic [7:0] OP_SCALE        = 8'h02;
  localparam logic [7:0] OP_OFFSET_X     = 8'h03;
  localparam logic [7:0] OP_OFFSET_Y     = 8'h04;
  localparam logic [7:0] OP_CLIP_LEFT    = 8'h05;
  localparam logic [7:0] OP_CLIP_RIGHT   = 8'h06;
  localparam logic [7:0] OP_CLIP_TOP     = 8'h07;
  localparam logic [7:0] OP_CLIP_BOTTOM  = 8'h08;
  localparam logic [7:0] OP_TRANSPARENCY = 8'h09;
  localparam logic [7:0] OP_FREEZE       = 8'h0A;
  localparam logic [7:0] OP_IMAGE        = 8'h0B;
  localparam logic [7:0] OP_COMMIT       = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_PAYLOAD,
    ST_IMG_X,
    ST_IMG_Y,
    ST_IMG_PIX,
    ST_DRAIN
  } state_t;

  function automatic int unsigned bytes_for(input int unsigned width);
    return (width + 7) / 8;
  endfunction

  function automatic logic is_reg_op(input logic [7:0] op);
    return (op >= OP_MODE) && (op <= OP_FREEZE);
  endfunction

endpackage

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI byte slave: synchronises the SPI pins into clk, assembles MSB-first
// bytes and shifts a status byte out on MISO.
module spi_byte_slave
  import pipeline_spi_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  input  logic [7:0] status,
  output logic       spi_miso,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ss_active
);

  logic [1:0] sclk_sync;
  logic [1:0] ss_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sreg;
  logic [6:0] tx_sreg;
  logic       sclk_rise;
  logic       sclk_fall;

  // ss synchroniser resets to "selected" so a select held low across reset
  // never looks like a fresh falling edge; armed waits for ss to be seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      ss_sync   <= 2'b00;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      ss_sync   <= {ss_sync[0], spi_ss};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign ss_active = armed & ~ss_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev  <= 1'b0;
      armed      <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_sreg    <= 7'd0;
      tx_sreg    <= 7'd0;
      spi_miso   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      sclk_prev  <= sclk_sync[1];
      byte_valid <= 1'b0;
      if (ss_sync[1]) armed <= 1'b1;
      if (!ss_active) begin
        bit_cnt  <= 3'd0;
        tx_sreg  <= status[6:0];
        spi_miso <= status[7];
      end else if (sclk_rise) begin
        rx_sreg <= {rx_sreg[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {rx_sreg, mosi_sync[1]};
        end
      end else if (sclk_fall) begin
        // falling edge after a completed byte starts a fresh status byte
        if (bit_cnt == 3'd0) begin
          tx_sreg  <= status[6:0];
          spi_miso <= status[7];
        end else begin
          tx_sreg  <= {tx_sreg[5:0], 1'b0};
          spi_miso <= tx_sreg[6];
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_spi_control_shadow.sv
// SPI-programmed overlay control registers with frame-synchronous shadow commit
// and a streamed image-pixel write port.
module pipeline_spi_control_shadow
  import pipeline_spi_defs::*;
#(
  parameter int PRECISION              = 12,
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int PIXEL_SIZE             = 16,
  parameter int RESOLUTION_X           = 480,
  parameter int RESOLUTION_Y           = 270
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  output logic [1:0]                        ctrl_overlay_mode,
  output logic [1:0]                        ctrl_fg_scale,
  output logic                              ctrl_fg_freeze,
  output logic [TRANSPARENCY_PRECISION-1:0] ctrl_fg_transparency,
  output logic signed [PRECISION:0]         ctrl_fg_offset_x,
  output logic signed [PRECISION:0]         ctrl_fg_offset_y,
  output logic [PRECISION-1:0]              ctrl_fg_clip_left,
  output logic [PRECISION-1:0]              ctrl_fg_clip_right,
  output logic [PRECISION-1:0]              ctrl_fg_clip_top,
  output logic [PRECISION-1:0]              ctrl_fg_clip_bottom,
  output logic [PRECISION-1:0]              ctrl_image_pixel_x,
  output logic [PRECISION-1:0]              ctrl_image_pixel_y,
  output logic [PIXEL_SIZE-1:0]             ctrl_image_pixel,
  output logic                              ctrl_image_pixel_ready,
  output logic                              ctrl_commit_pending,
  input  logic                              hw_spi_clk,
  input  logic                              hw_spi_ss,
  input  logic                              hw_spi_mosi,
  output logic                              hw_spi_miso
);

  localparam int OFS_W     = PRECISION + 1;
  localparam int PIX_BYTES = PIXEL_SIZE / 8;
  localparam int PAY_W     = (PIXEL_SIZE > 16) ? PIXEL_SIZE : 16;

  localparam logic [2:0]           PIX_LAST  = 3'(PIX_BYTES - 1);
  localparam logic [15:0]          RES_X16   = 16'(RESOLUTION_X);
  localparam logic [15:0]          RES_Y16   = 16'(RESOLUTION_Y);
  localparam logic [PRECISION-1:0] LAST_X    = PRECISION'(RESOLUTION_X - 1);
  localparam logic [PRECISION-1:0] LAST_Y    = PRECISION'(RESOLUTION_Y - 1);
  localparam logic [PRECISION-1:0] COORD_ONE = PRECISION'(1);

  typedef struct packed {
    logic [1:0]                        mode;
    logic [1:0]                        scale;
    logic                              freeze;
    logic [TRANSPARENCY_PRECISION-1:0] transparency;
    logic [OFS_W-1:0]                  offset_x;
    logic [OFS_W-1:0]                  offset_y;
    logic [PRECISION-1:0]              clip_left;
    logic [PRECISION-1:0]              clip_right;
    logic [PRECISION-1:0]              clip_top;
    logic [PRECISION-1:0]              clip_bottom;
  } ctrl_t;

  function automatic logic [2:0] payload_bytes(input logic [7:0] op);
    case (op)
      OP_OFFSET_X, OP_OFFSET_Y:  return 3'(bytes_for(OFS_W));
      OP_CLIP_LEFT, OP_CLIP_RIGHT,
      OP_CLIP_TOP, OP_CLIP_BOTTOM: return 3'(bytes_for(PRECISION));
      OP_TRANSPARENCY:           return 3'(bytes_for(TRANSPARENCY_PRECISION));
      default:                   return 3'd1;
    endcase
  endfunction

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             ss_active;
  logic [7:0]       status;

  state_t               state;
  logic [7:0]           opcode;
  logic [6:0]           last_op;
  logic [2:0]           byte_cnt;
  logic [PAY_W-9:0]     payload;
  logic [PAY_W-1:0]     assembled;
  logic [15:0]          start_x;
  logic [PRECISION-1:0] cur_x;
  logic [PRECISION-1:0] cur_y;
  ctrl_t                shadow;
  ctrl_t                active;
  logic                 commit_req;

  assign status    = {ctrl_commit_pending, last_op};
  assign assembled = {payload, byte_data};

  spi_byte_slave u_slave (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (hw_spi_clk),
    .spi_ss     (hw_spi_ss),
    .spi_mosi   (hw_spi_mosi),
    .status     (status),
    .spi_miso   (hw_spi_miso),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ss_active  (ss_active)
  );

  assign commit_req = frame_start |
                      (ss_active && state == ST_OPCODE && byte_valid && byte_data == OP_COMMIT);

  // Commit and shadow write share one edge: active picks up the pre-write shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      opcode                 <= 8'd0;
      last_op                <= 7'd0;
      byte_cnt               <= 3'd0;
      payload                <= '0;
      start_x                <= 16'd0;
      cur_x                  <= '0;
      cur_y                  <= '0;
      shadow                 <= '0;
      active                 <= '0;
      ctrl_image_pixel_x     <= '0;
      ctrl_image_pixel_y     <= '0;
      ctrl_image_pixel       <= '0;
      ctrl_image_pixel_ready <= 1'b0;
    end else begin
      ctrl_image_pixel_ready <= 1'b0;
      if (commit_req) active <= shadow;

      if (!ss_active) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_OPCODE;
            byte_cnt <= 3'd0;
            payload  <= '0;
          end
          ST_OPCODE: if (byte_valid) begin
            opcode   <= byte_data;
            last_op  <= byte_data[6:0];
            byte_cnt <= 3'd0;
            if (is_reg_op(byte_data))       state <= ST_PAYLOAD;
            else if (byte_data == OP_IMAGE) state <= ST_IMG_X;
            else                            state <= ST_DRAIN;
          end
          ST_PAYLOAD: if (byte_valid) begin
            payload  <= assembled[PAY_W-9:0];
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == payload_bytes(opcode) - 3'd1) begin
              state <= ST_DRAIN;
              case (opcode)
                OP_MODE:         shadow.mode         <= assembled[1:0];
                OP_SCALE:        shadow.scale        <= assembled[1:0];
                OP_OFFSET_X:     shadow.offset_x     <= assembled[OFS_W-1:0];
                OP_OFFSET_Y:     shadow.offset_y     <= assembled[OFS_W-1:0];
                OP_CLIP_LEFT:    shadow.clip_left    <= assembled[PRECISION-1:0];
                OP_CLIP_RIGHT:   shadow.clip_right   <= assembled[PRECISION-1:0];
                OP_CLIP_TOP:     shadow.clip_top     <= assembled[PRECISION-1:0];
                OP_CLIP_BOTTOM:  shadow.clip_bottom  <= assembled[PRECISION-1:0];
                OP_TRANSPARENCY: shadow.transparency <= assembled[TRANSPARENCY_PRECISION-1:0];
                OP_FREEZE:       shadow.freeze       <= assembled[0];
                default: ;
              endcase
            end
          end
          ST_IMG_X: if (byte_valid) begin
            payload <= assembled[PAY_W-9:0];
            if (byte_cnt[0]) begin
              start_x  <= assembled[15:0];
              byte_cnt <= 3'd0;
              state    <= ST_IMG_Y;
            end else begin
              byte_cnt <= 3'd1;
            end
          end
          ST_IMG_Y: if (byte_valid) begin
            payload <= assembled[PAY_W-9:0];
            if (byte_cnt[0]) begin
              byte_cnt <= 3'd0;
              // an out-of-frame start suppresses the whole stream
              if (start_x >= RES_X16 || assembled[15:0] >= RES_Y16) begin
                state <= ST_DRAIN;
              end else begin
                cur_x <= start_x[PRECISION-1:0];
                cur_y <= assembled[PRECISION-1:0];
                state <= ST_IMG_PIX;
              end
            end else begin
              byte_cnt <= 3'd1;
            end
          end
          ST_IMG_PIX: if (byte_valid) begin
            payload <= assembled[PAY_W-9:0];
            if (byte_cnt == PIX_LAST) begin
              byte_cnt               <= 3'd0;
              ctrl_image_pixel       <= assembled[PIXEL_SIZE-1:0];
              ctrl_image_pixel_x     <= cur_x;
              ctrl_image_pixel_y     <= cur_y;
              ctrl_image_pixel_ready <= 1'b1;
              if (cur_x == LAST_X) begin
                cur_x <= '0;
                cur_y <= (cur_y == LAST_Y) ? '0 : cur_y + COORD_ONE;
              end else begin
                cur_x <= cur_x + COORD_ONE;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          ST_DRAIN: state <= ST_DRAIN;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ctrl_overlay_mode    = active.mode;
  assign ctrl_fg_scale        = active.scale;
  assign ctrl_fg_freeze       = active.freeze;
  assign ctrl_fg_transparency = active.transparency;
  assign ctrl_fg_offset_x     = signed'(active.offset_x);
  assign ctrl_fg_offset_y     = signed'(active.offset_y);
  assign ctrl_fg_clip_left    = active.clip_left;
  assign ctrl_fg_clip_right   = active.clip_right;
  assign ctrl_fg_clip_top     = active.clip_top;
  assign ctrl_fg_clip_bottom  = active.clip_bottom;
  assign ctrl_commit_pending  = (shadow != active);

endmodule

// File: tb/tb_pipeline_spi_control_shadow.sv
// Randomised SPI master with a register/pixel reference model and a pixel
// scoreboard for pipeline_spi_control_shadow.
module tb_pipeline_spi_control_shadow;

  localparam int RX = 480;
  localparam int RY = 270;
  localparam int PB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [1:0]  ctrl_overlay_mode, ctrl_fg_scale;
  logic        ctrl_fg_freeze;
  logic [2:0]  ctrl_fg_transparency;
  logic signed [12:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
  logic [11:0] ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom;
  logic [11:0] ctrl_image_pixel_x, ctrl_image_pixel_y;
  logic [15:0] ctrl_image_pixel;
  logic        ctrl_image_pixel_ready, ctrl_commit_pending;
  logic        sclk, ss, mosi, miso;

  pipeline_spi_control_shadow dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .ctrl_overlay_mode(ctrl_overlay_mode), .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_freeze(ctrl_fg_freeze), .ctrl_fg_transparency(ctrl_fg_transparency),
    .ctrl_fg_offset_x(ctrl_fg_offset_x), .ctrl_fg_offset_y(ctrl_fg_offset_y),
    .ctrl_fg_clip_left(ctrl_fg_clip_left), .ctrl_fg_clip_right(ctrl_fg_clip_right),
    .ctrl_fg_clip_top(ctrl_fg_clip_top), .ctrl_fg_clip_bottom(ctrl_fg_clip_bottom),
    .ctrl_image_pixel_x(ctrl_image_pixel_x), .ctrl_image_pixel_y(ctrl_image_pixel_y),
    .ctrl_image_pixel(ctrl_image_pixel), .ctrl_image_pixel_ready(ctrl_image_pixel_ready),
    .ctrl_commit_pending(ctrl_commit_pending),
    .hw_spi_clk(sclk), .hw_spi_ss(ss), .hw_spi_mosi(mosi), .hw_spi_miso(miso)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: register values indexed by opcode 1..10.
  logic [31:0] sh_m [1:10];
  logic [31:0] ac_m [1:10];
  logic [6:0]  last_op_m;
  logic [39:0] exp_q [$];
  logic [7:0]  txb [$];

  function automatic int width_of(input int op);
    case (op)
      1, 2: return 2;
      3, 4: return 13;
      5, 6, 7, 8: return 12;
      9: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit pending_m();
    for (int i = 1; i <= 10; i++) if (sh_m[i] != ac_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic commit_m();
    for (int i = 1; i <= 10; i++) ac_m[i] = sh_m[i];
  endtask

  task automatic reset_m();
    for (int i = 1; i <= 10; i++) begin sh_m[i] = 0; ac_m[i] = 0; end
    last_op_m = 7'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_mode"},   32'(ctrl_overlay_mode), ac_m[1]);
    check({tag, "_scale"},  32'(ctrl_fg_scale), ac_m[2]);
    check({tag, "_offx"},   {19'b0, ctrl_fg_offset_x}, ac_m[3]);
    check({tag, "_offy"},   {19'b0, ctrl_fg_offset_y}, ac_m[4]);
    check({tag, "_clipl"},  32'(ctrl_fg_clip_left), ac_m[5]);
    check({tag, "_clipr"},  32'(ctrl_fg_clip_right), ac_m[6]);
    check({tag, "_clipt"},  32'(ctrl_fg_clip_top), ac_m[7]);
    check({tag, "_clipb"},  32'(ctrl_fg_clip_bottom), ac_m[8]);
    check({tag, "_transp"}, 32'(ctrl_fg_transparency), ac_m[9]);
    check({tag, "_freeze"}, 32'(ctrl_fg_freeze), ac_m[10]);
    check({tag, "_pending"}, 32'(ctrl_commit_pending), 32'(pending_m()));
  endtask

  // Mode-0 master, sclk = clk/8; frame_start can be aligned with the last bit's capture.
  task automatic send_byte(input logic [7:0] d, input int nbits, input bit fs, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = d[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      rx[i] = miso;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (fs && i == 0) frame_start = (k == 3);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_frame(input string tag);
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    commit_m();
    repeat (2) @(negedge clk);
    check_regs(tag);
  endtask

  task automatic run_txn(input string tag, input int fs_idx, input int last_bits);
    logic [7:0]  rx, op;
    logic [15:0] sx, sy, pix;
    int nb, p, k, n;
    op = txb[0];
    sx = 16'hFFFF; sy = 16'hFFFF;
    if (op == 8'h0B && txb.size() >= 5) begin sx = {txb[1], txb[2]}; sy = {txb[3], txb[4]}; end
    ss = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < txb.size(); b++) begin
      nb = (b == txb.size() - 1) ? last_bits : 8;
      if (op == 8'h0B && nb == 8 && b >= 5 && ((b - 4) % PB) == 0 && sx < RX && sy < RY) begin
        k = (b - 4) / PB - 1;
        p = (int'(sy) * RX + int'(sx) + k) % (RX * RY);
        pix = 16'd0;
        for (int j = 0; j < PB; j++) pix = {pix[7:0], txb[b - PB + 1 + j]};
        exp_q.push_back({12'(p % RX), 12'(p / RX), pix});
      end
      send_byte(txb[b], nb, (b == fs_idx), rx);
      if (nb == 8) begin
        if (b == 0) begin
          check({tag, "_miso0"}, 32'(rx), 32'({pending_m(), last_op_m}));
          last_op_m = op[6:0];
          if (op == 8'h0C) commit_m();
        end else if (b == 1) begin
          check({tag, "_miso1"}, 32'(rx), 32'({pending_m(), last_op_m}));
        end
        if (b == fs_idx) commit_m();
        if (op >= 8'd1 && op <= 8'd10 && b > 0) begin
          n = (width_of(int'(op)) + 7) / 8;
          if (b == n) begin
            logic [31:0] val;
            val = 0;
            for (int j = 1; j <= n; j++) val = (val << 8) | 32'(txb[j]);
            sh_m[op] = val & ((32'd1 << width_of(int'(op))) - 32'd1);
          end
        end
      end
    end
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check_regs(tag);
  endtask

  // Pixel scoreboard monitor.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (ctrl_image_pixel_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d pix=0x%0h, expected no pulse",
                   ctrl_image_pixel_x, ctrl_image_pixel_y, ctrl_image_pixel);
        end else begin
          e = exp_q.pop_front();
          if ({ctrl_image_pixel_x, ctrl_image_pixel_y, ctrl_image_pixel} !== e) begin
            failed++;
            $display("FAIL pix: got x=%0d y=%0d pix=0x%0h, expected x=%0d y=%0d pix=0x%0h",
                     ctrl_image_pixel_x, ctrl_image_pixel_y, ctrl_image_pixel,
                     e[39:28], e[27:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] rx, op;
    int n, fs, lb, sx, sy;
    rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; frame_start = 1'b0;
    reset_m();
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset_ready", 32'(ctrl_image_pixel_ready), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // offset_x = -10 becomes active only on the frame boundary
    txb = '{8'h03, 8'hFF, 8'hF6};
    run_txn("offx_pre", -1, 8);
    pulse_frame("offx_post");
    check("offx_m10", 32'(int'(ctrl_fg_offset_x)), 32'hFFFF_FFF6);

    // image write wrapping at the bottom-right corner
    txb = '{8'h0B, 8'h01, 8'hDF, 8'h01, 8'h0D, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
    run_txn("img_wrap", -1, 8);
    check("img_wrap_drain", 32'(exp_q.size()), 32'd0);
    check("pix_hold", {8'h0, ctrl_image_pixel_x, ctrl_image_pixel_y}, {8'h0, 12'd1, 12'd0});
    check("pix_hold_data", 32'(ctrl_image_pixel), 32'h0000_CCCC);

    // truncated clip_left payload
    txb = '{8'h05, 8'h12};
    run_txn("clip_trunc", -1, 8);

    // transparency write coincident with frame_start
    txb = '{8'h09, 8'h05};
    run_txn("transp_fs", 1, 8);
    pulse_frame("transp_next");

    // out-of-range start x: no pixels, status shows 0x0B
    txb = '{8'h0B, 8'h01, 8'hE0, 8'h00, 8'h00, 8'hAB, 8'hCD};
    run_txn("img_oob", -1, 8);

    for (int t = 0; t < 25; t++) begin
      int r;
      r = $urandom_range(0, 9);
      txb.delete();
      fs = -1; lb = 8;
      if (r == 0) op = 8'h0C;
      else if (r == 1) op = 8'h40 | 8'($urandom_range(0, 15));
      else op = 8'($urandom_range(1, 10));
      txb.push_back(op);
      if (op >= 8'd1 && op <= 8'd10) begin
        n = (width_of(int'(op)) + 7) / 8;
        for (int j = 0; j < n; j++) txb.push_back(8'($urandom));
        case ($urandom_range(0, 4))
          0: fs = n;
          1: txb.push_back(8'($urandom));
          2: lb = $urandom_range(1, 7);
          3: if (n == 2) void'(txb.pop_back());
          default: ;
        endcase
      end else if (op != 8'h0C) begin
        txb.push_back(8'($urandom));
      end
      run_txn("rand", fs, lb);
      if ($urandom_range(0, 2) == 0) pulse_frame("rand_frame");
    end

    // asynchronous reset in the middle of a pixel
    ss = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h0B, 8, 1'b0, rx);
    send_byte(8'h00, 8, 1'b0, rx);
    send_byte(8'h0A, 8, 1'b0, rx);
    send_byte(8'h00, 8, 1'b0, rx);
    send_byte(8'h05, 8, 1'b0, rx);
    send_byte(8'h12, 4, 1'b0, rx);
    rst_n = 1'b0;
    reset_m();
    #1;
    check_regs("rst_mid");
    check("rst_ready", 32'(ctrl_image_pixel_ready), 32'd0);
    check("rst_pix", {8'h0, ctrl_image_pixel_x, ctrl_image_pixel_y}, 32'd0);
    check("rst_pixdata", 32'(ctrl_image_pixel), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    send_byte(8'h34, 8, 1'b0, rx);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h56, 8, 1'b0, rx);
    send_byte(8'h78, 8, 1'b0, rx);
    send_byte(8'h9A, 8, 1'b0, rx);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check_regs("rst_after");

    txb = '{8'h01, 8'h03};
    run_txn("post_rst", -1, 8);
    pulse_frame("post_rst_frame");

    for (int t = 0; t < 3; t++) begin
      sx = $urandom_range(RX - 6, RX - 1);
      sy = (t == 2) ? RY : $urandom_range(RY - 3, RY - 1);
      txb = '{8'h0B, 8'(sx >> 8), 8'(sx), 8'(sy >> 8), 8'(sy)};
      for (int j = 0; j < 4 * PB; j++) txb.push_back(8'($urandom));
      run_txn("img_rand", -1, 8);
    end

    repeat (10) @(negedge clk);
    check("pix_missing", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_spi_control_shadow.md
PIPELINE_SPI_CONTROL_SHADOW -- requirements
Module: pipeline_spi_control_shadow

Interface
REQ-001 SHALL have parameter PRECISION, default 12, unsigned coordinate/clip width.
REQ-002 SHALL have parameter TRANSPARENCY_PRECISION, default 3, transparency width.
REQ-003 SHALL have parameter PIXEL_SIZE, default 16, pixel width; multiple of 8, max 32.
REQ-004 SHALL have parameters RESOLUTION_X and RESOLUTION_Y, defaults 480 and 270, image-write wrap bounds.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_start, input, 1, one-clk pulse at each frame boundary; the shadow-commit strobe.
REQ-008 SHALL have ports ctrl_overlay_mode (2), ctrl_fg_scale (2), ctrl_fg_freeze (1), ctrl_fg_transparency (TRANSPARENCY_PRECISION), all outputs, active control values.
REQ-009 SHALL have outputs ctrl_fg_offset_x and ctrl_fg_offset_y, signed PRECISION+1, active offsets.
REQ-010 SHALL have outputs ctrl_fg_clip_left/right/top/bottom, PRECISION each, active clip values.
REQ-011 SHALL have outputs ctrl_image_pixel_x/y (PRECISION), ctrl_image_pixel (PIXEL_SIZE), ctrl_image_pixel_ready (1), for the streamed image pixel.
REQ-012 SHALL have outputs ctrl_commit_pending (1), meaning shadow differs from active.
REQ-013 SHALL have ports hw_spi_clk, hw_spi_ss (active-low), hw_spi_mosi (inputs, 1) and hw_spi_miso (output, 1); SPI mode 0, MSB first.

Function
REQ-014 SHALL pass SPI inputs through 2-flop synchronisers and detect edges in the clk domain; hw_spi_clk SHALL NOT exceed clk/8.
REQ-015 SHALL treat the first byte after ss falls as the opcode; the following bytes are payload, big-endian, ceil(width/8) bytes, excess MSBs discarded.
REQ-016 Opcodes: 0x01 mode, 0x02 scale, 0x03 offset_x, 0x04 offset_y, 0x05-0x08 clip L/R/T/B, 0x09 transparency, 0x0A freeze, 0x0B image write, 0x0C immediate commit; all others ignored until ss rises.
REQ-017 Register opcodes SHALL write a shadow register only when the final payload byte is complete; extra bytes in the same transaction are ignored.
REQ-018 On frame_start or opcode 0x0C completion, all shadow registers SHALL copy to active outputs the next clk; ctrl_commit_pending clears the same clk.
REQ-019 Simultaneous frame_start and shadow write: the commit SHALL take the pre-write shadow value; the new value stays pending.
REQ-020 Opcode 0x0B: payload x (2 bytes), y (2 bytes), then repeated PIXEL_SIZE/8-byte pixels until ss rises.
REQ-021 Each completed pixel SHALL drive ctrl_image_pixel_ready high for exactly one clk, with x/y/pixel valid that clk and held until the next pulse.
REQ-022 After each pixel, x SHALL increment; x = RESOLUTION_X-1 wraps to 0 with y+1; y = RESOLUTION_Y-1 wraps to 0.
REQ-023 If start x >= RESOLUTION_X or start y >= RESOLUTION_Y, the write SHALL emit no pixels.
REQ-024 ss rising mid-byte or mid-payload SHALL discard the partial byte and value, with no register change, and return to opcode state.
REQ-025 FSM states: IDLE, OPCODE, PAYLOAD, IMG_X, IMG_Y, IMG_PIX, DRAIN; ss low moves IDLE->OPCODE; ss high moves any state to IDLE.
REQ-026 MISO SHALL shift status byte {commit_pending, last 7-bit opcode}, updated on SPI falling edges, bit 7 presented before the first rising edge.

Reset
REQ-027 rst_n low SHALL asynchronously clear all active, shadow, pixel registers and outputs to 0, ready to 0, miso to 0, FSM to IDLE.
REQ-028 A transaction in flight across reset SHALL be discarded; the block resumes on the next ss falling edge.

Structure
REQ-029 Opcode constants and state encodings SHALL live in a shared header, pipeline_spi_defs.
REQ-030 Synchroniser, bit shifting and MISO shifting SHALL live in one sub-module, spi_byte_slave, emitting byte_valid/byte_data/ss_active.

Verification
REQ-031 Send 0x03 0xFF 0xF6, then pulse frame_start -> ctrl_fg_offset_x = -10 only after the pulse; pending 1 then 0.
REQ-032 Send 0x0B x=479 y=269 with three pixels 0xAAAA,0xBBBB,0xCCCC -> three ready pulses at (479,269),(0,0),(1,0).
REQ-033 Send 0x05 with 1 byte then raise ss -> clip_left unchanged, pending stays 0.
REQ-034 Complete 0x09 0x05 on the same clk as frame_start -> transparency unchanged that frame; pending 1; next frame_start -> 5.
REQ-035 Assert rst_n low mid-0x0B pixel -> all outputs 0 immediately; no ready pulse; next transaction works normally.
REQ-036 Send 0x0B x=480 y=0 with one pixel -> no ready pulse; MISO next byte reads 0x0B.
